vp_pair_scheduler: RTL and testbench

- Sits between the VPEncoder output side and a single shared MAC lane.
- VPEncoder presents two 3-entry bundles, left and right. Each entry is an address triplet, a weight and an input activation.
- This block arbitrates between the two bundle sources round-robin and pops the winning bundle. It then serializes the bundle's valid entries onto one valid/ready stream.
- It counts bundles against a programmed total and signals completion.

---
 rtl/vp_pair_scheduler_if.sv | 39 +++
 rtl/vp_pair_scheduler.sv | 147 ++++++++++++++
 tb/tb_vp_pair_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/vp_pair_scheduler_if.sv
// rtl/vp_pair_scheduler_if.sv - bundle inputs, pop acks and MAC entry stream of the pair scheduler
interface vp_pair_scheduler_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16,
    parameter int LANES  = 3
);
    logic                        i_left_ready;
    logic [LANES-1:0]            i_left_mask;
    logic [LANES*3*ADDR_W-1:0]   i_left_addr;
    logic [LANES*DATA_W-1:0]     i_left_w;
    logic [LANES*DATA_W-1:0]     i_left_ia;
    logic                        i_right_ready;
    logic [LANES-1:0]            i_right_mask;
    logic [LANES*3*ADDR_W-1:0]   i_right_addr;
    logic [LANES*DATA_W-1:0]     i_right_w;
    logic [LANES*DATA_W-1:0]     i_right_ia;
    logic                        o_left_ack;
    logic                        o_right_ack;
    logic                        o_valid;
    logic                        i_ready;
    logic [3*ADDR_W-1:0]         o_addr;
    logic [DATA_W-1:0]           o_w;
    logic [DATA_W-1:0]           o_ia;
    logic                        o_src;

    modport master (
        input  i_left_ready, i_left_mask, i_left_addr, i_left_w, i_left_ia,
        input  i_right_ready, i_right_mask, i_right_addr, i_right_w, i_right_ia,
        input  i_ready,
        output o_left_ack, o_right_ack, o_valid, o_addr, o_w, o_ia, o_src
    );

    modport slave (
        output i_left_ready, i_left_mask, i_left_addr, i_left_w, i_left_ia,
        output i_right_ready, i_right_mask, i_right_addr, i_right_w, i_right_ia,
        output i_ready,
        input  o_left_ack, o_right_ack, o_valid, o_addr, o_w, o_ia, o_src
    );
endinterface

// File: rtl/vp_pair_scheduler.sv
// rtl/vp_pair_scheduler.sv - round-robin pop of left/right VPEncoder bundles, serialized onto one MAC lane
module vp_pair_scheduler #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16,
    parameter int LANES  = 3,
    parameter int CNT_W  = 11
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_bundles,
    output logic              o_busy,
    output logic              o_done,
    vp_pair_scheduler_if.master bus
);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW3   = 3 * ADDR_W;

    typedef enum logic [1:0] {IDLE, ARB, ISSUE, DONE} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]          target_q, target_d;
    logic                      last_q, last_d;
    logic                      src_q, src_d;
    logic [LANES-1:0]          mask_q, mask_d;
    logic [LANES*AW3-1:0]      addr_q, addr_d;
    logic [LANES*DATA_W-1:0]   w_q, w_d;
    logic [LANES*DATA_W-1:0]   ia_q, ia_d;
    logic [IDX_W-1:0]          idx_q, idx_d;

    logic                      grant_l, grant_r;
    logic [LANES-1:0]          sel_mask;
    logic [IDX_W:0]            first_hit, next_hit;
    logic [CNT_W-1:0]          cnt_inc;
    logic                      last_bundle;

    // Returns {found, index} of the lowest set bit of m at or above position from.
    function automatic logic [IDX_W:0] first_set(input logic [LANES-1:0] m, input int from);
        logic [IDX_W:0] r;
        r = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (m[k] && (k >= from)) r = {1'b1, IDX_W'(k)};
        end
        return r;
    endfunction

    // last_q == 1 means right won last, so left has priority on a tie.
    assign grant_l = i_rst_n && (state_q == ARB) && bus.i_left_ready &&
                     (!bus.i_right_ready || last_q);
    assign grant_r = i_rst_n && (state_q == ARB) && bus.i_right_ready &&
                     (!bus.i_left_ready || !last_q);

    assign sel_mask    = grant_r ? bus.i_right_mask : bus.i_left_mask;
    assign first_hit   = first_set(sel_mask, 0);
    assign next_hit    = first_set(mask_q, int'(idx_q) + 1);
    assign cnt_inc     = cnt_q + 1'b1;
    assign last_bundle = (cnt_inc == target_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        last_d   = last_q;
        src_d    = src_q;
        mask_d   = mask_q;
        addr_d   = addr_q;
        w_d      = w_q;
        ia_d     = ia_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    target_d = i_bundles;
                    cnt_d    = '0;
                    last_d   = 1'b1;
                    state_d  = (i_bundles == '0) ? DONE : ARB;
                end
            end
            ARB: begin
                if (grant_l || grant_r) begin
                    mask_d = sel_mask;
                    addr_d = grant_r ? bus.i_right_addr : bus.i_left_addr;
                    w_d    = grant_r ? bus.i_right_w    : bus.i_left_w;
                    ia_d   = grant_r ? bus.i_right_ia   : bus.i_left_ia;
                    last_d = grant_r;
                    src_d  = grant_r;
                    if (sel_mask != '0) begin
                        idx_d   = first_hit[IDX_W-1:0];
                        state_d = ISSUE;
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = last_bundle ? DONE : ARB;
                    end
                end
            end
            ISSUE: begin
                if (bus.i_ready) begin
                    if (next_hit[IDX_W]) begin
                        idx_d = next_hit[IDX_W-1:0];
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = last_bundle ? DONE : ARB;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= '0;
            last_q   <= 1'b1;
            src_q    <= 1'b0;
            mask_q   <= '0;
            addr_q   <= '0;
            w_q      <= '0;
            ia_q     <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            last_q   <= last_d;
            src_q    <= src_d;
            mask_q   <= mask_d;
            addr_q   <= addr_d;
            w_q      <= w_d;
            ia_q     <= ia_d;
            idx_q    <= idx_d;
        end
    end

    assign bus.o_left_ack  = grant_l;
    assign bus.o_right_ack = grant_r;
    assign bus.o_valid     = (state_q == ISSUE);
    assign bus.o_addr      = addr_q[int'(idx_q)*AW3 +: AW3];
    assign bus.o_w         = w_q[int'(idx_q)*DATA_W +: DATA_W];
    assign bus.o_ia        = ia_q[int'(idx_q)*DATA_W +: DATA_W];
    assign bus.o_src       = src_q;
    assign o_busy          = (state_q != IDLE);
    assign o_done          = (state_q == DONE);
endmodule

// File: tb/tb_vp_pair_scheduler.sv
// tb/tb_vp_pair_scheduler.sv - directed checks of arbitration, serialization, stall, empty and reset cases
module tb_vp_pair_scheduler;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;
    localparam int LANES  = 3;
    localparam int CNT_W  = 11;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_start;
    logic [CNT_W-1:0] i_bundles;
    logic             o_busy;
    logic             o_done;

    int n_cmp;
    int n_err;

    vp_pair_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES)) bus ();

    vp_pair_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .i_bundles (i_bundles),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .bus       (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [20:0] a0, a1, a2;

    initial begin
        n_cmp = 0;
        n_err = 0;
        a0 = 21'h012345;
        a1 = 21'h0ABCDE;
        a2 = 21'h155555;

        // Reset with start and both readies asserted
        i_rst_n = 1'b0;
        i_start = 1'b1;
        i_bundles = 11'd3;
        bus.i_left_ready  = 1'b1;
        bus.i_right_ready = 1'b1;
        bus.i_left_mask   = 3'b111;
        bus.i_right_mask  = 3'b111;
        bus.i_left_addr   = {a2, a1, a0};
        bus.i_right_addr  = {a0, a1, a2};
        bus.i_left_w      = {16'd30, 16'd20, 16'd10};
        bus.i_left_ia     = {16'd3, 16'd2, 16'd1};
        bus.i_right_w     = {16'd300, 16'd200, 16'd100};
        bus.i_right_ia    = {16'd6, 16'd5, 16'd4};
        bus.i_ready       = 1'b1;
        step();
        step();
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_lack", bus.o_left_ack, 0);
        chk("rst_rack", bus.o_right_ack, 0);
        chk("rst_done", o_done, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_w", bus.o_w, 0);
        i_start = 1'b0;
        i_rst_n = 1'b1;
        step();
        chk("rst_idle_busy", o_busy, 0);

        // Single source, two full bundles
        bus.i_right_ready = 1'b0;
        i_bundles = 11'd2;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            chk("ss_arb_lack", bus.o_left_ack, 1);
            chk("ss_arb_rack", bus.o_right_ack, 0);
            chk("ss_arb_valid", bus.o_valid, 0);
            chk("ss_arb_busy", o_busy, 1);
            step();
            chk("ss_v0", bus.o_valid, 1);
            chk("ss_w0", bus.o_w, 10);
            chk("ss_ia0", bus.o_ia, 1);
            chk("ss_a0", bus.o_addr, a0);
            chk("ss_src0", bus.o_src, 0);
            chk("ss_ack_in_issue", bus.o_left_ack, 0);
            step();
            chk("ss_w1", bus.o_w, 20);
            chk("ss_a1", bus.o_addr, a1);
            step();
            chk("ss_w2", bus.o_w, 30);
            chk("ss_a2", bus.o_addr, a2);
            chk("ss_done_early", o_done, 0);
            step();
        end
        chk("ss_done", o_done, 1);
        chk("ss_done_valid", bus.o_valid, 0);
        step();
        chk("ss_done_pulse", o_done, 0);
        chk("ss_idle", o_busy, 0);

        // Round-robin, both sides ready, single-entry bundles
        bus.i_right_ready = 1'b1;
        bus.i_left_mask   = 3'b001;
        bus.i_right_mask  = 3'b001;
        i_bundles = 11'd4;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk("rr_lack", bus.o_left_ack, (b % 2) == 0);
            chk("rr_rack", bus.o_right_ack, (b % 2) == 1);
            step();
            chk("rr_valid", bus.o_valid, 1);
            chk("rr_src", bus.o_src, b % 2);
            chk("rr_w", bus.o_w, (b % 2) ? 100 : 10);
            chk("rr_acks_in_issue", {bus.o_left_ack, bus.o_right_ack}, 0);
            step();
        end
        chk("rr_done", o_done, 1);
        step();

        // Sparse mask with a stall on the first entry
        bus.i_right_ready = 1'b0;
        bus.i_left_mask   = 3'b101;
        i_bundles = 11'd1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        bus.i_ready = 1'b0;
        chk("sp_lack", bus.o_left_ack, 1);
        step();
        chk("sp_v0", bus.o_valid, 1);
        chk("sp_w0", bus.o_w, 10);
        step();
        chk("sp_hold_v", bus.o_valid, 1);
        chk("sp_hold_w", bus.o_w, 10);
        chk("sp_hold_a", bus.o_addr, a0);
        bus.i_ready = 1'b1;
        step();
        chk("sp_w2", bus.o_w, 30);
        chk("sp_a2", bus.o_addr, a2);
        chk("sp_v2", bus.o_valid, 1);
        step();
        chk("sp_done", o_done, 1);
        step();

        // Empty bundle
        bus.i_left_mask = 3'b000;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("em_lack", bus.o_left_ack, 1);
        chk("em_valid", bus.o_valid, 0);
        step();
        chk("em_done", o_done, 1);
        chk("em_valid2", bus.o_valid, 0);
        step();
        chk("em_idle", o_busy, 0);

        // Zero total
        i_bundles = 11'd0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("z_done", o_done, 1);
        chk("z_lack", bus.o_left_ack, 0);
        step();
        chk("z_idle", o_busy, 0);
        chk("z_done_pulse", o_done, 0);

        // Reset while issuing, then a fresh run
        bus.i_left_mask = 3'b111;
        i_bundles = 11'd2;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        chk("mr_valid_pre", bus.o_valid, 1);
        i_rst_n = 1'b0;
        #1;
        chk("mr_lack_in_rst", bus.o_left_ack, 0);
        step();
        chk("mr_valid", bus.o_valid, 0);
        chk("mr_busy", o_busy, 0);
        i_rst_n = 1'b1;
        step();
        chk("mr_idle", o_busy, 0);
        chk("mr_no_ack", bus.o_left_ack, 0);
        bus.i_left_mask = 3'b010;
        i_bundles = 11'd1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("mr_arb_lack", bus.o_left_ack, 1);
        step();
        chk("mr_w1", bus.o_w, 20);
        chk("mr_src", bus.o_src, 0);
        step();
        chk("mr_done", o_done, 1);
        step();
        chk("mr_end_idle", o_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
